tcam_pri: RTL and testbench

TCAM_PRI -- requirements
Module: tcam_pri

---
 rtl/tcam_pri.sv | 178 +++++++++++++++++
 tb/tb_tcam_pri.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tcam_pri.sv
// ---------------------------------------------------------------------------
// tcam_pri -- ternary CAM with lowest-index priority resolution
//
// Each entry holds a value, a care mask (1 = compare, 0 = don't care) and a
// valid bit. A search compares the key against every entry in parallel. The
// lowest matching index wins. The search runs through a two-stage,
// backpressured pipeline:
//   p1 : registered DEPTH-bit match vector
//   p2 : registered priority-encoded result
//
// Optional feature: define TCAM_HIT_COUNT_EN to enable the saturating 16-bit
// counter of consumed hit results. When the macro is undefined, hit_count
// is tied to zero and no counter logic is built.
//
// Ports
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   wr_en           : write/invalidate strobe for entry wr_addr
//   wr_addr         : entry index
//   wr_data/wr_mask : stored value / care mask
//   wr_valid        : 1 installs the entry, 0 invalidates it
//   search_valid    : search request handshake input
//   search_ready    : search request handshake output
//   search_key      : search key
//   result_valid    : result handshake output
//   result_ready    : result handshake input
//   result_hit      : any entry matched
//   result_multi    : two or more entries matched
//   result_index    : lowest matching index (0 on miss)
//   result_data     : stored value of result_index (0 on miss)
//   hit_count       : consumed-hit counter (0 unless TCAM_HIT_COUNT_EN)
// ---------------------------------------------------------------------------
module tcam_pri #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] wr_mask,
    input  logic             wr_valid,
    input  logic             search_valid,
    input  logic [WIDTH-1:0] search_key,
    output logic             search_ready,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             result_hit,
    output logic             result_multi,
    output logic [AW-1:0]    result_index,
    output logic [WIDTH-1:0] result_data,
    output logic [15:0]      hit_count
);

    logic [WIDTH-1:0] r_data  [DEPTH];
    logic [WIDTH-1:0] r_mask  [DEPTH];
    logic [DEPTH-1:0] r_valid;

    logic             r_vld_p1;
    logic [DEPTH-1:0] r_match_p1;

    logic             r_vld_p2;
    logic             r_hit_p2;
    logic             r_multi_p2;
    logic [AW-1:0]    r_index_p2;
    logic [WIDTH-1:0] r_data_p2;

    logic             w_s2_stall;
    logic             w_s2_load;
    logic             w_s1_load;
    logic [DEPTH-1:0] w_match;
    logic [DEPTH-1:0] w_match_p1;
    logic             w_hit;
    logic             w_multi;
    logic [AW-1:0]    w_index;
    logic [AW:0]      w_popcnt;
    logic [WIDTH-1:0] w_rdata;

    // S2 stalls only while it holds an unconsumed result; S1 may load
    // whenever it is empty or can hand its contents to S2.
    assign w_s2_stall   = r_vld_p2 && !result_ready;
    assign w_s2_load    = !w_s2_stall;
    assign w_s1_load    = !(r_vld_p1 && w_s2_stall);
    assign search_ready = w_s1_load;

    // Entry array: compares in this cycle see contents before this edge's write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_mask[i] <= '0;
            end
        end else if (wr_en) begin
            r_valid[wr_addr] <= wr_valid;
            r_data[wr_addr]  <= wr_data;
            r_mask[wr_addr]  <= wr_mask;
        end
    end

    always_comb begin
        w_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = r_valid[i] && (((search_key ^ r_data[i]) & r_mask[i]) == '0);
        end
    end

    // ---- stage p1: match vector ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1   <= 1'b0;
            r_match_p1 <= '0;
        end else if (w_s1_load) begin
            r_vld_p1   <= search_valid;
            r_match_p1 <= w_match;
        end
    end

    // A bubble in S1 resolves to a clean miss so S2 never shows stale fields.
    assign w_match_p1 = r_vld_p1 ? r_match_p1 : '0;

    always_comb begin
        w_index  = '0;
        w_popcnt = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_match_p1[i]) begin
                w_index = AW'(i);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_popcnt = w_popcnt + {{AW{1'b0}}, w_match_p1[i]};
        end
        w_hit   = |w_match_p1;
        w_multi = (w_popcnt >= (AW+1)'(2));
        w_rdata = w_hit ? r_data[w_index] : '0;
    end

    // ---- stage p2: resolved result ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2   <= 1'b0;
            r_hit_p2   <= 1'b0;
            r_multi_p2 <= 1'b0;
            r_index_p2 <= '0;
            r_data_p2  <= '0;
        end else if (w_s2_load) begin
            r_vld_p2   <= r_vld_p1;
            r_hit_p2   <= w_hit;
            r_multi_p2 <= w_multi;
            r_index_p2 <= w_index;
            r_data_p2  <= w_rdata;
        end
    end

    assign result_valid = r_vld_p2;
    assign result_hit   = r_hit_p2;
    assign result_multi = r_multi_p2;
    assign result_index = r_index_p2;
    assign result_data  = r_data_p2;

`ifdef TCAM_HIT_COUNT_EN
    logic [15:0] r_hit_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count <= '0;
        end else if (r_vld_p2 && result_ready && r_hit_p2 && (r_hit_count != 16'hFFFF)) begin
            r_hit_count <= r_hit_count + 16'd1;
        end
    end

    assign hit_count = r_hit_count;
`else
    assign hit_count = '0;
`endif

endmodule

// File: tb/tb_tcam_pri.sv
module tb_tcam_pri;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] wr_mask;
    logic             wr_valid;
    logic             search_valid;
    logic [WIDTH-1:0] search_key;
    logic             search_ready;
    logic             result_valid;
    logic             result_ready;
    logic             result_hit;
    logic             result_multi;
    logic [AW-1:0]    result_index;
    logic [WIDTH-1:0] result_data;
    logic [15:0]      hit_count;

    int n_pass = 0;
    int n_chk  = 0;

    tcam_pri #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_mask     (wr_mask),
        .wr_valid    (wr_valid),
        .search_valid(search_valid),
        .search_key  (search_key),
        .search_ready(search_ready),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_hit  (result_hit),
        .result_multi(result_multi),
        .result_index(result_index),
        .result_data (result_data),
        .hit_count   (hit_count)
    );

    always #5 clk = ~clk;

`ifdef TCAM_HIT_COUNT_EN
    localparam logic [15:0] EXP_HC_AFTER_TWO = 16'd2;
`else
    localparam logic [15:0] EXP_HC_AFTER_TWO = 16'd0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_res(input string tag, input logic hit, input logic [AW-1:0] idx,
                           input logic [WIDTH-1:0] data, input logic multi);
        chk({tag, ".valid"}, 32'(result_valid), 32'd1);
        chk({tag, ".hit"},   32'(result_hit),   32'(hit));
        chk({tag, ".index"}, 32'(result_index), 32'(idx));
        chk({tag, ".data"},  32'(result_data),  32'(data));
        chk({tag, ".multi"}, 32'(result_multi), 32'(multi));
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                      input logic [WIDTH-1:0] m, input logic v);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m; wr_valid = v;
        step();
        wr_en = 1'b0;
    endtask

    // Issue one search, expect the result two edges later, then let it drain.
    task automatic search(input string tag, input logic [WIDTH-1:0] key, input logic hit,
                          input logic [AW-1:0] idx, input logic [WIDTH-1:0] data, input logic multi);
        search_valid = 1'b1; search_key = key;
        step();
        search_valid = 1'b0;
        chk({tag, ".lat1"}, 32'(result_valid), 32'd0);
        step();
        chk_res(tag, hit, idx, data, multi);
        step();
        chk({tag, ".drain"}, 32'(result_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0; wr_valid = 1'b0;
        search_valid = 1'b0; search_key = '0; result_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst.valid", 32'(result_valid), 32'd0);
        chk("rst.hit",   32'(result_hit),   32'd0);
        chk("rst.multi", 32'(result_multi), 32'd0);
        chk("rst.index", 32'(result_index), 32'd0);
        chk("rst.data",  32'(result_data),  32'd0);
        chk("rst.hc",    32'(hit_count),    32'd0);
        chk("rst.sready",32'(search_ready), 32'd1);

        wr(2'd0, 8'hA5, 8'hFF, 1'b1);
        wr(2'd1, 8'hF0, 8'hF0, 1'b1);
        wr(2'd2, 8'h0F, 8'h0F, 1'b1);
        wr(2'd3, 8'h3C, 8'hFC, 1'b1);

        search("sA5", 8'hA5, 1'b1, 2'd0, 8'hA5, 1'b0);
        search("sF1", 8'hF1, 1'b1, 2'd1, 8'hF0, 1'b0);
        chk("hc.two", 32'(hit_count), 32'(EXP_HC_AFTER_TWO));
        search("s00", 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
        search("sFF", 8'hFF, 1'b1, 2'd1, 8'hF0, 1'b1);
        search("s3F", 8'h3F, 1'b1, 2'd2, 8'h0F, 1'b1);

        // Back-to-back searches, one per cycle.
        search_valid = 1'b1; search_key = 8'hA5;
        step();
        search_key = 8'hF1;
        step();
        chk_res("b2b0", 1'b1, 2'd0, 8'hA5, 1'b0);
        search_key = 8'h00;
        step();
        chk_res("b2b1", 1'b1, 2'd1, 8'hF0, 1'b0);
        search_valid = 1'b0;
        step();
        chk_res("b2b2", 1'b0, 2'd0, 8'h00, 1'b0);
        step();
        chk("b2b.drain", 32'(result_valid), 32'd0);

        // Backpressure: consumer stalls three edges while three searches are offered.
        result_ready = 1'b0;
        search_valid = 1'b1; search_key = 8'hA5;
        step();
        chk("bp.sready0", 32'(search_ready), 32'd1);
        search_key = 8'hF1;
        step();
        chk_res("bp.hold0", 1'b1, 2'd0, 8'hA5, 1'b0);
        chk("bp.sready1", 32'(search_ready), 32'd0);
        search_key = 8'h00;
        step();
        chk_res("bp.hold1", 1'b1, 2'd0, 8'hA5, 1'b0);
        chk("bp.sready2", 32'(search_ready), 32'd0);
        step();
        chk_res("bp.hold2", 1'b1, 2'd0, 8'hA5, 1'b0);
        result_ready = 1'b1;
        #1;
        chk("bp.sready3", 32'(search_ready), 32'd1);
        step();
        search_valid = 1'b0;
        chk_res("bp.r1", 1'b1, 2'd1, 8'hF0, 1'b0);
        step();
        chk_res("bp.r2", 1'b0, 2'd0, 8'h00, 1'b0);
        step();
        chk("bp.drain", 32'(result_valid), 32'd0);

        // Invalidate entry 1, then same-cycle write/search.
        wr(2'd1, 8'hF0, 8'hF0, 1'b0);
        search("inv", 8'hF1, 1'b0, 2'd0, 8'h00, 1'b0);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hF1; wr_mask = 8'hFF; wr_valid = 1'b1;
        search_valid = 1'b1; search_key = 8'hF1;
        step();
        wr_en = 1'b0; search_valid = 1'b0;
        step();
        chk_res("samecyc", 1'b0, 2'd0, 8'h00, 1'b0);
        step();
        search("after", 8'hF1, 1'b1, 2'd0, 8'hF1, 1'b0);

        // Reset while a search is in flight.
        search_valid = 1'b1; search_key = 8'hF1;
        step();
        rst = 1'b1; search_valid = 1'b0;
        step();
        rst = 1'b0;
        chk("rmid.valid0", 32'(result_valid), 32'd0);
        step();
        chk("rmid.valid1", 32'(result_valid), 32'd0);
        chk("rmid.hc",     32'(hit_count),    32'd0);
        chk("rmid.sready", 32'(search_ready), 32'd1);
        search("empty", 8'hF1, 1'b0, 2'd0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
